mult_hilo_sequencer: RTL

//  Sequences the multi-cycle multiplier behind mult/multu and owns the HI/LO product registers read by mfhi/mflo.

---
 rtl/mult_hilo_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/mult_hilo_sequencer.sv
// Multi-cycle shift-add multiplier sequencer owning the HI/LO product registers.
// Optional feature: define MULT_EARLY_OUT_EN to leave RUN once the remaining multiplier bits are zero.
module mult_hilo_sequencer #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             kill,
    input  logic             hilo_rd,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int STEPS = WIDTH / BPC;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state, state_next;
    logic [2*WIDTH-1:0]   acc, mcand, partial, product;
    logic [WIDTH-1:0]     mplier, mag_a, mag_b;
    logic [CW-1:0]        count;
    logic                 neg, last_step, accept;

    assign busy   = (state != IDLE);
    assign stall  = (hilo_rd & (busy | start)) | (start & busy);
    assign accept = (state == IDLE) & start & ~kill;

    // Magnitudes fit in WIDTH unsigned bits, including 2^(WIDTH-1).
    assign mag_a = (sgn & srca[WIDTH-1]) ? (~srca + ONE_W) : srca;
    assign mag_b = (sgn & srcb[WIDTH-1]) ? (~srcb + ONE_W) : srcb;

    assign product = neg ? (~acc + ONE_2W) : acc;

`ifdef MULT_EARLY_OUT_EN
    assign last_step = (count == CW'(1)) || ((mplier >> BPC) == '0);
`else
    assign last_step = (count == CW'(1));
`endif

    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < BPC; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = RUN;
            RUN: begin
                if (kill)           state_next = IDLE;
                else if (last_step) state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        count  <= CW'(STEPS);
                        neg    <= sgn & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                    end
                end
                RUN: begin
                    if (!kill) begin
                        acc    <= acc + partial;
                        mcand  <= mcand << BPC;
                        mplier <= mplier >> BPC;
                        count  <= count - CW'(1);
                    end
                end
                FIX: begin
                    // kill wins over the result write
                    if (!kill) begin
                        hi <= product[2*WIDTH-1:WIDTH];
                        lo <= product[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
